// File: rtl/mem_arbiter_if.sv
// =============================================================================
// Module   : mem_arbiter_if
// Summary  : Line-transfer bus shared by both caches and the slow memory port.
// Revision : 1.0
// =============================================================================
`default_nettype none

interface mem_arbiter_if;
  logic          read;
  logic          write;
  logic [31:4]   addr;
  logic [127:0]  wdata;
  logic [127:0]  rdata;
  logic          ready;

  // master issues requests, slave answers with data and the ready strobe
  modport master (output read, write, addr, wdata, input  rdata, ready);
  modport slave  (input  read, write, addr, wdata, output rdata, ready);
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// =============================================================================
// Module   : mem_arbiter
// Summary  : Shares one slow memory port between the I-cache and D-cache.
//            Macro ARB_RR_EN selects round-robin ties instead of D priority.
// Revision : 1.0
// =============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic     clk,
  input  wire logic     proc_reset,
  mem_arbiter_if.slave  i_port,
  mem_arbiter_if.slave  d_port,
  mem_arbiter_if.master mem_port
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   i_pend, d_pend;
  logic   tie_to_i;
  logic   grant_i, grant_d;

  assign i_pend = i_port.read | i_port.write;
  assign d_pend = d_port.read | d_port.write;

`ifdef ARB_RR_EN
  logic last_d_q, last_d_d;

  assign tie_to_i = last_d_q;
`else
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] starve_q, starve_d;

  // D normally wins a tie; I takes it once D has starved it long enough
  assign tie_to_i = (starve_q == LIMIT);
`endif

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_pend && d_pend) begin
          grant_i = tie_to_i;
          grant_d = ~tie_to_i;
        end else begin
          grant_i = i_pend;
          grant_d = d_pend;
        end
        if (grant_i)      state_d = GNT_I;
        else if (grant_d) state_d = GNT_D;
      end
      GNT_I: begin
        if (mem_port.ready) state_d = RELEASE;
        else if (!i_pend)   state_d = IDLE;
      end
      GNT_D: begin
        if (mem_port.ready) state_d = RELEASE;
        else if (!d_pend)   state_d = IDLE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

`ifdef ARB_RR_EN
  always_comb begin
    last_d_d = last_d_q;
    if (grant_i)      last_d_d = 1'b0;
    else if (grant_d) last_d_d = 1'b1;
  end

  // reset state means "I served last", so the first tie goes to D
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) last_d_q <= 1'b0;
    else            last_d_q <= last_d_d;
  end
`else
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_i || !i_pend)
        starve_d = 3'd0;
      else if (grant_d && (starve_q != LIMIT))
        starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) starve_q <= 3'd0;
    else            starve_q <= starve_d;
  end
`endif

  always_comb begin
    mem_port.read  = 1'b0;
    mem_port.write = 1'b0;
    mem_port.addr  = '0;
    mem_port.wdata = '0;
    case (state_q)
      GNT_I: begin
        mem_port.read  = i_port.read;
        mem_port.write = i_port.write;
        mem_port.addr  = i_port.addr;
        mem_port.wdata = i_port.wdata;
      end
      GNT_D: begin
        mem_port.read  = d_port.read;
        mem_port.write = d_port.write;
        mem_port.addr  = d_port.addr;
        mem_port.wdata = d_port.wdata;
      end
      default: begin
        mem_port.read  = 1'b0;
        mem_port.write = 1'b0;
      end
    endcase
  end

  assign i_port.rdata = mem_port.rdata;
  assign d_port.rdata = mem_port.rdata;
  assign i_port.ready = (state_q == GNT_I) & mem_port.ready;
  assign d_port.ready = (state_q == GNT_D) & mem_port.ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// =============================================================================
// Module   : tb_mem_arbiter
// Summary  : Self-checking bench for mem_arbiter with a transaction-level model.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  mem_arbiter_if i_bus();
  mem_arbiter_if d_bus();
  mem_arbiter_if mem_bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_port     (i_bus),
    .d_port     (d_bus),
    .mem_port   (mem_bus)
  );

  int total = 0;
  int bad   = 0;

  // model: owner 0=none 1=I 2=D, plus the post-transfer dead cycle
  int m_owner, m_stv;
  bit m_release, m_last_d;
  logic          e_read, e_write, e_iready, e_dready;
  logic [31:4]   e_addr;
  logic [127:0]  e_wdata;

  // cache agents, index 0=I 1=D
  bit            c_req[2], c_wr[2], persist[2], got_ready[2];
  logic [31:4]   c_addr[2];
  logic [127:0]  c_wdata[2];
  bit            rand_mode, mem_auto;
  int            mem_age, mem_lat, n_i, n_d;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_data(input logic [31:4] a);
    return {a, 4'hA, a, 4'hB, a, 4'hC, a, 4'hD};
  endfunction

  task automatic drive();
    i_bus.read  = c_req[0] & ~c_wr[0];
    i_bus.write = c_req[0] &  c_wr[0];
    i_bus.addr  = c_addr[0];
    i_bus.wdata = c_wdata[0];
    d_bus.read  = c_req[1] & ~c_wr[1];
    d_bus.write = c_req[1] &  c_wr[1];
    d_bus.addr  = c_addr[1];
    d_bus.wdata = c_wdata[1];
  endtask

  task automatic raise(input int k, input bit wr, input logic [31:4] a, input logic [127:0] wd);
    c_req[k] = 1'b1; c_wr[k] = wr; c_addr[k] = a; c_wdata[k] = wd;
    drive();
  endtask

  function automatic void calc_exp();
    int own;
    own = proc_reset ? 0 : m_owner;
    e_read = 1'b0; e_write = 1'b0; e_addr = '0; e_wdata = '0;
    if (own == 1) begin
      e_read = i_bus.read; e_write = i_bus.write; e_addr = i_bus.addr; e_wdata = i_bus.wdata;
    end else if (own == 2) begin
      e_read = d_bus.read; e_write = d_bus.write; e_addr = d_bus.addr; e_wdata = d_bus.wdata;
    end
    e_iready = (own == 1) && mem_bus.ready;
    e_dready = (own == 2) && mem_bus.ready;
  endfunction

  function automatic void model_step();
    bit ip, dp;
    int win;
    ip = i_bus.read | i_bus.write;
    dp = d_bus.read | d_bus.write;
    if (proc_reset) begin
      m_owner = 0; m_release = 0; m_stv = 0; m_last_d = 0;
    end else if (m_release) begin
      m_release = 0;
    end else if (m_owner == 0) begin
      win = 0;
      if (ip && dp) begin
`ifdef ARB_RR_EN
        win = m_last_d ? 1 : 2;
`else
        win = (m_stv >= STARVE_LIMIT) ? 1 : 2;
`endif
      end else if (ip) win = 1;
      else if (dp)     win = 2;
      if (win == 1 || !ip)                      m_stv = 0;
      else if (win == 2 && m_stv < STARVE_LIMIT) m_stv = m_stv + 1;
      if (win != 0) m_last_d = (win == 2);
      m_owner = win;
    end else begin
      if (mem_bus.ready) begin
        m_owner = 0; m_release = 1;
      end else if (!((m_owner == 1) ? ip : dp)) begin
        m_owner = 0;
      end
    end
  endfunction

  // called just after a falling edge: memory reacts, then outputs are compared
  task automatic sample();
    calc_exp();
    if (mem_auto) begin
      if (e_read || e_write) begin
        if (mem_age == 0 && rand_mode) mem_lat = $urandom_range(1, 4);
        mem_age++;
        mem_bus.ready = (mem_age >= mem_lat);
      end else begin
        mem_age = 0;
        mem_bus.ready = rand_mode && ($urandom_range(0, 7) == 0);
      end
      mem_bus.rdata = mem_bus.ready ? line_data(e_addr) : {4{$urandom()}};
    end
    calc_exp();
    #1;
    chk("mem_read",  128'(mem_bus.read),  128'(e_read));
    chk("mem_write", 128'(mem_bus.write), 128'(e_write));
    chk("mem_addr",  128'(mem_bus.addr),  128'(e_addr));
    chk("mem_wdata", mem_bus.wdata,       e_wdata);
    chk("i_ready",   128'(i_bus.ready),   128'(e_iready));
    chk("d_ready",   128'(d_bus.ready),   128'(e_dready));
    chk("i_rdata",   i_bus.rdata,         mem_bus.rdata);
    chk("d_rdata",   d_bus.rdata,         mem_bus.rdata);
    if (i_bus.ready === 1'b1) n_i++;
    if (d_bus.ready === 1'b1) n_d++;
    got_ready[0] = e_iready;
    got_ready[1] = e_dready;
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (c_req[k] && got_ready[k]) c_req[k] = 1'b0;
      else if (c_req[k] && rand_mode && $urandom_range(0, 39) == 0) c_req[k] = 1'b0;
      else if (!c_req[k] && persist[k]) c_req[k] = 1'b1;
      else if (!c_req[k] && rand_mode && $urandom_range(0, 2) == 0) begin
        c_req[k] = 1'b1; c_wr[k] = 1'($urandom_range(0, 1));
        c_addr[k] = 28'($urandom()); c_wdata[k] = {4{$urandom()}};
      end
    end
    drive();
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    c_req[0] = 0; c_req[1] = 0; persist[0] = 0; persist[1] = 0;
    drive();
    sample(); adv();
    proc_reset = 1'b0;
  endtask

  initial begin
    int  i_at, grants, seen_i;
    bit  prev_rd;
    int  seq[6];
    m_owner = 0; m_stv = 0; m_release = 0; m_last_d = 0;
    for (int k = 0; k < 2; k++) begin
      c_req[k] = 0; c_wr[k] = 0; persist[k] = 0; got_ready[k] = 0;
      c_addr[k] = '0; c_wdata[k] = '0;
    end
    rand_mode = 0; mem_auto = 0; mem_age = 0; mem_lat = 1; n_i = 0; n_d = 0;
    proc_reset = 1'b1;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = 128'h0123456789abcdef_fedcba9876543210;
    drive();
    @(negedge clk);

    // reset state, with a D request already waiting
    raise(1, 0, 28'h0000050, '0);
    sample();
    chk("rst_mem_read",  128'(mem_bus.read),  128'd0);
    chk("rst_mem_addr",  128'(mem_bus.addr),  128'd0);
    chk("rst_d_ready",   128'(d_bus.ready),   128'd0);
    chk("rst_i_rdata",   i_bus.rdata, 128'h0123456789abcdef_fedcba9876543210);
    adv();
    proc_reset = 1'b0;
    mem_auto = 1;
    sample(); chk("post_rst_no_grant", 128'(mem_bus.read), 128'd0); adv();
    sample(); chk("post_rst_grant", 128'(mem_bus.read), 128'd1); adv();
    for (int c = 0; c < 4; c++) begin sample(); adv(); end

    // single I read, memory answers on the fifth grant cycle
    n_i = 0; n_d = 0; mem_lat = 5;
    raise(0, 0, 28'h0000010, '0);
    sample(); chk("t30_idle_read", 128'(mem_bus.read), 128'd0); adv();
    sample();
    chk("t30_read", 128'(mem_bus.read), 128'd1);
    chk("t30_addr", 128'(mem_bus.addr), 128'h0000010);
    adv();
    for (int c = 0; c < 12; c++) begin
      sample();
      if (i_bus.ready === 1'b1) chk("t30_rdata_hi", 128'(i_bus.rdata[127:96]), 128'h0000010A);
      adv();
    end
    chk("t30_iready_pulses", 128'(n_i), 128'd1);
    chk("t30_dready_pulses", 128'(n_d), 128'd0);

    // simultaneous I and D requests
    n_i = 0; mem_lat = 2; i_at = -1;
    raise(0, 0, 28'h0000030, '0);
    raise(1, 0, 28'h0000040, '0);
    for (int c = 0; c < 20; c++) begin
      sample();
      if (c == 1) chk("t31_d_first", 128'(mem_bus.addr), 128'h0000040);
      if (i_at < 0 && mem_bus.read === 1'b1 && mem_bus.addr == 28'h0000030) i_at = c;
      if (i_bus.ready === 1'b1) chk("t31_rdata_hi", 128'(i_bus.rdata[127:96]), 128'h0000030A);
      adv();
    end
    chk("t31_i_grant_cycle", 128'(i_at), 128'd5);
    chk("t31_iready_pulses", 128'(n_i), 128'd1);

`ifdef ARB_RR_EN
    // both requesting continuously: alternation starting with D
    do_reset();
    mem_lat = 1; grants = 0; prev_rd = 0;
    persist[0] = 1; persist[1] = 1;
    raise(0, 0, 28'h0000100, '0);
    raise(1, 0, 28'h0000200, '0);
    for (int c = 0; c < 200 && grants < 6; c++) begin
      sample();
      if (mem_bus.read === 1'b1 && !prev_rd) begin
        seq[grants] = (mem_bus.addr == 28'h0000200) ? 2 : 1;
        grants++;
      end
      prev_rd = (mem_bus.read === 1'b1);
      adv();
    end
    chk("t33_grant_count", 128'(grants), 128'd6);
    for (int g = 0; g < 6; g++) chk("t33_alternation", 128'(seq[g]), 128'((g % 2 == 0) ? 2 : 1));
`else
    // D keeps requesting while I waits: bounded starvation
    do_reset();
    mem_lat = 1; grants = 0; seen_i = 0; prev_rd = 0;
    persist[1] = 1;
    raise(0, 0, 28'h0000100, '0);
    raise(1, 0, 28'h0000200, '0);
    for (int c = 0; c < 200 && seen_i == 0; c++) begin
      sample();
      if (mem_bus.read === 1'b1 && !prev_rd) begin
        if (mem_bus.addr == 28'h0000100) seen_i = 1;
        else grants++;
      end
      prev_rd = (mem_bus.read === 1'b1);
      adv();
    end
    chk("t32_i_granted", 128'(seen_i), 128'd1);
    chk("t32_d_grants_before_i", 128'(grants), 128'd4);
`endif
    persist[0] = 0; persist[1] = 0;
    for (int c = 0; c < 20; c++) begin sample(); adv(); end

    // reset in the third grant cycle of a D write
    do_reset();
    n_d = 0; mem_lat = 50;
    raise(1, 1, 28'h0000020, {4{32'hDEADBEEF}});
    sample(); adv();
    sample();
    chk("t34_write", 128'(mem_bus.write), 128'd1);
    chk("t34_wdata", mem_bus.wdata, {4{32'hDEADBEEF}});
    adv();
    sample(); adv();
    proc_reset = 1'b1;
    sample(); chk("t34_write_drop", 128'(mem_bus.write), 128'd0); adv();
    proc_reset = 1'b0;
    c_req[1] = 0; drive();
    raise(0, 0, 28'h0000060, '0);
    mem_lat = 2;
    sample(); chk("t34_idle_after_rst", 128'(mem_bus.read), 128'd0); adv();
    sample(); chk("t34_next_grant", 128'(mem_bus.addr), 128'h0000060); adv();
    for (int c = 0; c < 6; c++) begin sample(); adv(); end
    chk("t34_dready_never", 128'(n_d), 128'd0);

    // spurious memory ready with nobody requesting
    mem_auto = 0; mem_bus.ready = 1'b1; n_i = 0; n_d = 0;
    sample();
    chk("t35_iready", 128'(i_bus.ready), 128'd0);
    chk("t35_dready", 128'(d_bus.ready), 128'd0);
    adv();
    sample(); adv();
    mem_bus.ready = 1'b0; mem_auto = 1; mem_lat = 1;
    raise(1, 0, 28'h0000070, '0);
    sample(); adv();
    sample(); chk("t35_still_idle", 128'(mem_bus.addr), 128'h0000070); adv();
    for (int c = 0; c < 4; c++) begin sample(); adv(); end

    // randomized traffic with occasional resets
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      proc_reset = ($urandom_range(0, 499) == 0);
      sample();
      adv();
    end
    proc_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
